// File: rtl/clock_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_bank
// Purpose  : Bank of NUM_CH independent programmable clock dividers. Each
//            channel makes a 50 % duty square wave whose half period is
//            (half + 1) clk_og cycles, plus a one-cycle tick that is
//            coincident with every rising edge of that square wave.
//            Half-period values can be loaded at runtime. Each channel has
//            its own run enable, and a global restart re-aligns all phases.
// Ports    : clk_og      - board clock, rising edge
//            rst_n       - asynchronous active-low reset
//            en_i        - per-channel run enable         [NUM_CH]
//            sync_clr_i  - synchronous restart of all channels
//            ld_en_i     - half-period load strobe
//            ld_ch_i     - channel selected for the load  [CH_W]
//            ld_half_i   - new half-period value          [CNT_W]
//            clk_out_o   - divided square waves           [NUM_CH]
//            tick_o      - rising-edge pulses             [NUM_CH]
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 26,
  parameter int DEF_HALF = 250000,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_og,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_clr_i,
  input  logic              ld_en_i,
  input  logic [CH_W-1:0]   ld_ch_i,
  input  logic [CNT_W-1:0]  ld_half_i,
  output logic [NUM_CH-1:0] clk_out_o,
  output logic [NUM_CH-1:0] tick_o
);

  localparam logic [CNT_W-1:0] c_DEF_HALF = CNT_W'(DEF_HALF);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [CH_W-1:0] c_CH_IDX = CH_W'(gi);

    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             out_q,  out_d;
    logic             tick_q, tick_d;
    logic             ld_hit;

    // A select value of NUM_CH or above matches no channel, so an
    // out-of-range load leaves every channel alone.
    assign ld_hit = ld_en_i && (ld_ch_i == c_CH_IDX);

    always_comb begin
      half_d = half_q;
      cnt_d  = cnt_q;
      out_d  = out_q;
      tick_d = 1'b0;

      // The half register is written by a load even when a global restart
      // happens on the same edge. Only the counter and output are cleared.
      if (ld_hit) begin
        half_d = ld_half_i;
      end

      if (sync_clr_i || ld_hit || !en_i[gi]) begin
        cnt_d  = '0;
        out_d  = 1'b0;
        tick_d = 1'b0;
      end else if (cnt_q < half_q) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        // Wrap: toggle. The tick fires only on the 0 -> 1 transition.
        cnt_d  = '0;
        out_d  = ~out_q;
        tick_d = ~out_q;
      end
    end

    always_ff @(posedge clk_og or negedge rst_n) begin
      if (!rst_n) begin
        half_q <= c_DEF_HALF;
        cnt_q  <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        half_q <= half_d;
        cnt_q  <= cnt_d;
        out_q  <= out_d;
        tick_q <= tick_d;
      end
    end

    assign clk_out_o[gi] = out_q;
    assign tick_o[gi]    = tick_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_bank
// Purpose  : Directed self-checking bench for clock_div_bank. The main
//            instance has 4 channels, 8-bit counters and a default half of 3
//            (period 8). A second 5-channel instance exercises a load select
//            value (5) that addresses no channel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_bank;

  logic       clk_og = 1'b0;
  logic       rst_n  = 1'b0;
  logic [3:0] en     = 4'h0;
  logic       sync_clr = 1'b0;
  logic       ld_en  = 1'b0;
  logic [1:0] ld_ch  = 2'd0;
  logic [7:0] ld_half = 8'd0;
  logic [3:0] clk_out;
  logic [3:0] tick;

  logic [4:0] en5      = 5'h1F;
  logic       sync5    = 1'b0;
  logic       ld_en5   = 1'b0;
  logic [2:0] ld_ch5   = 3'd5;
  logic [4:0] clk_out5;
  logic [4:0] tick5;

  int errors = 0;
  int checks = 0;
  int n_edge = 0;

  // Expected outputs on the 1st..8th edge after a restart with halves 1,3,7,3
  logic [3:0] pa_o [8] = '{4'h0, 4'h1, 4'h1, 4'hA, 4'hA, 4'hB, 4'hB, 4'h4};
  logic [3:0] pa_t [8] = '{4'h0, 4'h1, 4'h0, 4'hA, 4'h0, 4'h1, 4'h0, 4'h4};

  clock_div_bank #(.NUM_CH(4), .CNT_W(8), .DEF_HALF(3)) dut (
    .clk_og     (clk_og),
    .rst_n      (rst_n),
    .en_i       (en),
    .sync_clr_i (sync_clr),
    .ld_en_i    (ld_en),
    .ld_ch_i    (ld_ch),
    .ld_half_i  (ld_half),
    .clk_out_o  (clk_out),
    .tick_o     (tick)
  );

  clock_div_bank #(.NUM_CH(5), .CNT_W(8), .DEF_HALF(3)) dut5 (
    .clk_og     (clk_og),
    .rst_n      (rst_n),
    .en_i       (en5),
    .sync_clr_i (sync5),
    .ld_en_i    (ld_en5),
    .ld_ch_i    (ld_ch5),
    .ld_half_i  (ld_half),
    .clk_out_o  (clk_out5),
    .tick_o     (tick5)
  );

  always #5 clk_og = ~clk_og;

  task automatic step();
    @(posedge clk_og);
    #1;
    n_edge++;
  endtask

  task automatic test_reset();
    logic [3:0] eo, et;
    rst_n = 1'b0;
    en = 4'hF;
    repeat (3) @(posedge clk_og);
    #1;
    checks++;
    if ({clk_out, tick} !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: clk_out=%h tick=%h required 0/0", clk_out, tick);
    end
    rst_n = 1'b1;
    n_edge = 0;
    for (int n = 1; n <= 24; n++) begin
      step();
      eo = (n >= 4 && ((n - 4) % 8) < 4) ? 4'hF : 4'h0;
      et = (n >= 4 && ((n - 4) % 8) == 0) ? 4'hF : 4'h0;
      checks++;
      if (clk_out !== eo) begin
        errors++;
        $display("FAIL default_clk edge %0d: got %h required %h", n, clk_out, eo);
      end
      checks++;
      if (tick !== et) begin
        errors++;
        $display("FAIL default_tick edge %0d: got %h required %h", n, tick, et);
      end
    end
  endtask

  task automatic test_load();
    logic o, c1, t0;
    step();
    step();
    ld_en = 1'b1; ld_ch = 2'd1; ld_half = 8'd0;
    step();
    ld_en = 1'b0;
    checks++;
    if ({clk_out, tick} !== 8'h00) begin
      errors++;
      $display("FAIL load_strobe: clk_out=%h tick=%h required 0/0", clk_out, tick);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      o  = (k < 4);
      t0 = (k == 0);
      c1 = ((k % 2) == 0);
      checks++;
      if (clk_out !== {o, o, c1, o}) begin
        errors++;
        $display("FAIL load_clk k=%0d: got %h required %h", k, clk_out, {o, o, c1, o});
      end
      checks++;
      if (tick !== {t0, t0, c1, t0}) begin
        errors++;
        $display("FAIL load_tick k=%0d: got %h required %h", k, tick, {t0, t0, c1, t0});
      end
    end
  endtask

  task automatic test_enable();
    step();
    checks++;
    if ({clk_out, tick} !== 8'hFF) begin
      errors++;
      $display("FAIL en_before: clk_out=%h tick=%h required F/F", clk_out, tick);
    end
    en = 4'b1011;
    step();
    checks++;
    if ({clk_out, tick} !== 8'h90) begin
      errors++;
      $display("FAIL en_drop: clk_out=%h tick=%h required 9/0", clk_out, tick);
    end
    step();
    checks++;
    if ({clk_out, tick} !== 8'hB2) begin
      errors++;
      $display("FAIL en_idle: clk_out=%h tick=%h required B/2", clk_out, tick);
    end
    en = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if ({clk_out[2], tick[2]} !== ((k == 4) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL en_restart edge %0d: clk_out2=%b tick2=%b required %b",
                 k, clk_out[2], tick[2], (k == 4));
      end
    end
  endtask

  task automatic test_back_to_back_and_align();
    ld_en = 1'b1; ld_ch = 2'd0; ld_half = 8'd1;
    step();
    ld_ch = 2'd1; ld_half = 8'd3;
    step();
    ld_ch = 2'd2; ld_half = 8'd7;
    step();
    ld_en = 1'b0;
    repeat (5) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    checks++;
    if ({clk_out, tick} !== 8'h00) begin
      errors++;
      $display("FAIL align_clear: clk_out=%h tick=%h required 0/0", clk_out, tick);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (clk_out !== pa_o[k]) begin
        errors++;
        $display("FAIL align_clk edge %0d: got %h required %h", k + 1, clk_out, pa_o[k]);
      end
      checks++;
      if (tick !== pa_t[k]) begin
        errors++;
        $display("FAIL align_tick edge %0d: got %h required %h", k + 1, tick, pa_t[k]);
      end
    end
  endtask

  task automatic test_bad_channel();
    logic [4:0] eo, et;
    ld_ch5 = 3'd5;
    ld_half = 8'd0;
    for (int j = 0; j < 11; j++) begin
      ld_en5 = (j < 3);
      step();
      eo = (((n_edge - 4) % 8) < 4) ? 5'h1F : 5'h00;
      et = (((n_edge - 4) % 8) == 0) ? 5'h1F : 5'h00;
      checks++;
      if ({clk_out5, tick5} !== {eo, et}) begin
        errors++;
        $display("FAIL bad_ch edge %0d: clk_out=%h tick=%h required %h/%h",
                 n_edge, clk_out5, tick5, eo, et);
      end
    end
    ld_en5 = 1'b0;
  endtask

  task automatic test_priority();
    logic [7:0] exp_a [4] = '{8'h00, 8'h00, 8'h11, 8'hBA};
    sync_clr = 1'b1; ld_en = 1'b1; ld_ch = 2'd0; ld_half = 8'd2;
    step();
    sync_clr = 1'b0; ld_en = 1'b0;
    checks++;
    if ({clk_out, tick} !== 8'h00) begin
      errors++;
      $display("FAIL clr_and_load: clk_out=%h tick=%h required 0/0", clk_out, tick);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({clk_out, tick} !== exp_a[k]) begin
        errors++;
        $display("FAIL clr_load_run edge %0d: got %h required %h",
                 k + 1, {clk_out, tick}, exp_a[k]);
      end
    end
    repeat (4) step();
    // Channel 0 would wrap and rise on this edge; the load must win.
    ld_en = 1'b1; ld_ch = 2'd0; ld_half = 8'd2;
    step();
    ld_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      checks++;
      if ({clk_out[0], tick[0]} !== ((k == 3) ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL load_vs_wrap k=%0d: clk_out0=%b tick0=%b required %b",
                 k, clk_out[0], tick[0], (k == 3));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] eo, et;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_out, tick, clk_out5, tick5} !== 18'h0) begin
      errors++;
      $display("FAIL async_reset: clk_out=%h tick=%h required 0/0", clk_out, tick);
    end
    #2;
    rst_n = 1'b1;
    n_edge = 0;
    for (int n = 1; n <= 5; n++) begin
      step();
      eo = (n >= 4) ? 4'hF : 4'h0;
      et = (n == 4) ? 4'hF : 4'h0;
      checks++;
      if ({clk_out, tick} !== {eo, et}) begin
        errors++;
        $display("FAIL post_reset edge %0d: clk_out=%h tick=%h required %h/%h",
                 n, clk_out, tick, eo, et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_enable();
    test_back_to_back_and_align();
    test_bad_channel();
    test_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
